// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width, counter sizing.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits. Purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] dv;
  logic           unused_r_msb;

  // The partial remainder is always below the divisor, so its top bit is zero here.
  assign sh           = {r[WIDTH-1:0], q_msb};
  assign dv           = {1'b0, divisor};
  assign q_bit        = (sh >= dv);
  assign r_next       = q_bit ? (sh - dv) : sh;
  assign unused_r_msb = r[WIDTH];

endmodule

// File: rtl/seq_div32.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_SIGNED_EN to honour in_signed (two's-complement, truncating) operations.
module seq_div32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fin, r_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q_msb  (dq_q[WIDTH-1]),
    .divisor(dvs_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  assign q_raw = {dq_q[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic dvd_neg, dvs_neg;

  always_comb begin
    dvd_neg = in_signed & dividend[WIDTH-1];
    dvs_neg = in_signed & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -divisor : divisor;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (state_q == ST_IDLE && in_valid) begin
      neg_q_d = dvd_neg ^ dvs_neg;
      neg_r_d = dvd_neg;
    end
    q_fin = neg_q_q ? -q_raw : q_raw;
    r_fin = neg_r_q ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
  assign dvd_mag          = dividend;
  assign dvs_mag          = divisor;
  assign q_fin            = q_raw;
  assign r_fin            = r_next[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dbz_d = (divisor == '0);
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            state_d = ST_DONE;
          end else begin
            cnt_d   = CW'(WIDTH - 1);
            r_d     = '0;
            dq_d    = dvd_mag;
            dvs_d   = dvs_mag;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        r_d   = r_next;
        dq_d  = q_raw;
        cnt_d = cnt_q - CW'(1);
        // Last step: results (with any sign fix) land directly in the output registers.
        if (cnt_q == '0) begin
          cnt_d   = '0;
          quo_d   = q_fin;
          rem_d   = r_fin;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div32.sv
// Directed bench for seq_div32: table of unsigned vectors plus hold, reset-abort and signed sequences.
module tb_seq_div32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests;
  int n_fail;

  seq_div32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .in_signed  (in_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Launch one operation at a negedge, scramble inputs after the handshake,
  // count edges from operand presentation until out_valid, then consume the result.
  task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                        output logic [31:0] q, output logic [31:0] r, output logic dbz,
                        output int lat);
    @(negedge clk);
    dividend  = dvd;
    divisor   = dvs;
    in_signed = sgn;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    in_signed = 1'($urandom_range(0, 1));
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t        tbl[9];
  logic [31:0] q, r;
  logic        dbz;
  int          lat;
  logic        hold_bad;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tbl[0] = '{32'd100,        32'd7,          1'b0, 32'd14,        32'd2,    1'b0, 33};
    tbl[1] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,    1'b0, 33};
    tbl[2] = '{32'd5,          32'd9,          1'b0, 32'd0,         32'd5,    1'b0, 33};
    tbl[3] = '{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1};
    tbl[4] = '{32'd0,          32'd5,          1'b0, 32'd0,         32'd0,    1'b0, 33};
    tbl[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,         32'd0,    1'b0, 33};
    tbl[6] = '{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA, 32'd2,    1'b0, 33};
    tbl[7] = '{32'd12345678,   32'd1000,       1'b0, 32'd12345,     32'd678,  1'b0, 33};
    tbl[8] = '{32'd1000000,    32'd1000,       1'b0, 32'd1000,      32'd0,    1'b0, 33};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    in_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].dvd, tbl[i].dvs, tbl[i].sgn, q, r, dbz, lat);
      check($sformatf("vec%0d_q", i), q, tbl[i].q);
      check($sformatf("vec%0d_r", i), r, tbl[i].r);
      check($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(tbl[i].dbz));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
    end

    // Result held under backpressure while a new request waits.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    dividend = 32'd999;
    divisor  = 32'd3;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("hold_reached", 32'(out_valid), 32'd1);
    hold_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (quotient !== 32'd14 || remainder !== 32'd2 || !out_valid || in_ready || div_by_zero)
        hold_bad = 1'b1;
    end
    check("hold_stable", 32'(hold_bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("done_ignores_in_valid", 32'(in_ready), 32'd1);
    check("done_released", 32'(out_valid), 32'd0);

    // Reset in the middle of a calculation aborts it.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("mid_calc_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_quotient", quotient, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd20, 32'd4, 1'b0, q, r, dbz, lat);
    check("post_rst_q", q, 32'd5);
    check("post_rst_r", r, 32'd0);
    check("post_rst_lat", 32'(lat), 32'd33);

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dbz, lat);
    check("s_m7_2_q", q, 32'hFFFF_FFFD);
    check("s_m7_2_r", r, 32'hFFFF_FFFF);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, dbz, lat);
    check("s_7_m2_q", q, 32'hFFFF_FFFD);
    check("s_7_m2_r", r, 32'd1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dbz, lat);
    check("s_min_m1_q", q, 32'h8000_0000);
    check("s_min_m1_r", r, 32'd0);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, q, r, dbz, lat);
    check("s_div0_q", q, 32'hFFFF_FFFF);
    check("s_div0_r", r, 32'hFFFF_FFF9);
    check("s_div0_dbz", 32'(dbz), 32'd1);
`else
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dbz, lat);
    check("u_sgn_ignored_q", q, 32'h7FFF_FFFC);
    check("u_sgn_ignored_r", r, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
